k_fifo2_ctrl: RTL and testbench
===============================

K_FIFO2_CTRL -- requirements
Module: k_fifo2_ctrl

Interface
REQ-001 SHALL have parameter: data_size, default 8, width of payload and RAM data.
REQ-002 SHALL have port: clk  input  1  single clock; all state on posedge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: in_valid input 1 push request; in_ready output 1 push accepted when high with in_valid; in_data input data_size push payload.
REQ-005 SHALL have ports: out_valid output 1 out_data holds an entry; out_ready input 1 consumer takes entry; out_data output data_size equal to ram_q.
REQ-006 SHALL have RAM ports: ram_wen output 1; ram_waddr output 1; ram_raddr output 1; ram_d output data_size; ram_q input data_size.
REQ-007 SHALL have port: count output 2, RAM occupancy 0..2, excluding the entry held on out_data.

Function
REQ-008 SHALL treat the RAM as single-operation per cycle: ram_wen=1 writes ram_d to mem[ram_waddr]; ram_wen=0 with a read issued loads ram_q from mem[ram_raddr] at the next edge; write and read never in the same cycle.
REQ-009 SHALL raise wr_req when in_valid && count<2.
REQ-010 SHALL raise rd_req when count>0 && (!out_valid || out_ready).
REQ-011 SHALL grant via 2-way round-robin: single request wins; both requests grant the one not granted last; reset priority is read.
REQ-012 SHALL drive in_ready = wr_req && wr_grant, which is combinational from in_valid, out_ready and state.
REQ-013 SHALL on write grant drive ram_wen=1, ram_waddr=wptr, ram_d=in_data, then toggle wptr and increment count.
REQ-014 SHALL on read grant drive ram_wen=0, ram_raddr=rptr, then toggle rptr and decrement count.
REQ-015 SHALL use one-cycle read latency: out_valid rises the cycle after a read grant, with out_data=ram_q.
REQ-016 SHALL update out_valid next = rd_grant ? 1 : (out_ready ? 0 : out_valid).
REQ-017 SHALL keep out_data stable while out_valid && !out_ready; no read issued then.
REQ-018 SHALL not change count when no grant occurs; count never exceeds 2 or underflows.
REQ-019 SHALL wrap pointers mod 2; FIFO order preserved across wrap.
REQ-020 SHALL give total capacity of 3 entries: 2 in RAM plus 1 on out_data.
REQ-021 SHALL drive ram_wen=0 and hold ram_waddr, ram_raddr and ram_d when idle (no grant).

Reset
REQ-022 SHALL on rst_n=0 immediately clear wptr=0, rptr=0, count=0, out_valid=0, in_ready=0, ram_wen=0, last_grant=write (so read wins first), stats counter=0.
REQ-023 SHALL discard entries in flight when reset is asserted mid-operation; RAM contents are don't-care; no write is issued during reset.
REQ-024 SHALL ignore out_data value until out_valid=1 after reset.

Configuration
REQ-025 SHALL, when macro K_FIFO2_CTRL_STATS_EN is defined, add output conflict_cnt[7:0] counting cycles where wr_req && rd_req both asserted, saturating at 255, cleared by reset.
REQ-026 SHALL, when K_FIFO2_CTRL_STATS_EN is undefined, have no conflict_cnt port or logic, with all other behaviour identical.

Structure
REQ-027 SHALL place in package k_fifo2_pkg: DEPTH=2, ADDR_SIZE=1, COUNT_W=2, and a grant enum {GNT_NONE, GNT_WR, GNT_RD}.
REQ-028 SHALL contain one sub-module, k_fifo2_rr_arb: 2-requester round-robin arbiter with last-grant register, inputs wr_req/rd_req, one-hot grant output.
REQ-029 SHALL keep the RAM external; the controller does not instantiate it.

Verification
REQ-030 SHALL cover: reset, push 0x11 with out_ready=0 -> write cycle 1, read cycle 2, out_valid=1 cycle 3 with out_data=0x11, count=0.
REQ-031 SHALL cover: out_ready=0, push 0x01..0x04 continuously -> first three accepted, in_ready=0 at count=2 with out_valid=1, 0x04 held off.
REQ-032 SHALL cover: then out_ready=1 -> out_data sequence 0x01,0x02,0x03,0x04 in order, wptr/rptr wrap, no loss.
REQ-033 SHALL cover: in_valid=1 and out_ready=1 held with count=1 -> grants alternate RD,WR,RD,WR; with K_FIFO2_CTRL_STATS_EN conflict_cnt increments each conflict cycle.
REQ-034 SHALL cover: rst_n pulsed low while count=2, out_valid=1 -> outputs cleared asynchronously before next edge, next push 0xAA emerges first.
REQ-035 SHALL cover: never ram_wen=1 in a read-grant cycle; 300 conflict cycles -> conflict_cnt=255.

Source files
------------

// File: rtl/k_fifo2_pkg.sv
// Shared constants and the grant encoding for the two-entry FIFO controller.
// Used by k_fifo2_ctrl and k_fifo2_rr_arb.
package k_fifo2_pkg;

    localparam int DEPTH     = 2;
    localparam int ADDR_SIZE = 1;
    localparam int COUNT_W   = 2;

    // Bit positions inside the arbiter's one-hot grant vector
    localparam int GNT_WR_BIT = 0;
    localparam int GNT_RD_BIT = 1;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WR,
        GNT_RD
    } grant_e;

endpackage

// File: rtl/k_fifo2_rr_arb.sv
// Two-requester round-robin arbiter between the RAM write and read requests.
// After reset the last grant is "write", so a read wins the first collision.
module k_fifo2_rr_arb
    import k_fifo2_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_req,
    input  logic       rd_req,
    output logic [1:0] grant
);

    grant_e last_q;
    grant_e last_d;
    grant_e cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= GNT_WR;
        end else begin
            last_q <= last_d;
        end
    end

    // A lone request always wins; a collision goes to whoever lost last time
    always_comb begin
        cur    = GNT_NONE;
        last_d = last_q;
        if (wr_req && rd_req) begin
            cur = (last_q == GNT_RD) ? GNT_WR : GNT_RD;
        end else if (wr_req) begin
            cur = GNT_WR;
        end else if (rd_req) begin
            cur = GNT_RD;
        end
        if (cur != GNT_NONE) begin
            last_d = cur;
        end
    end

    always_comb begin
        grant             = '0;
        grant[GNT_WR_BIT] = (cur == GNT_WR);
        grant[GNT_RD_BIT] = (cur == GNT_RD);
    end

endmodule

// File: rtl/k_fifo2_ctrl.sv
// Controller for a 3-deep FIFO: two entries in an external single-port RAM plus one on out_data.
// Define K_FIFO2_CTRL_STATS_EN to add the saturating conflict_cnt output.
module k_fifo2_ctrl
    import k_fifo2_pkg::*;
#(
    parameter int data_size = 8
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [data_size-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [data_size-1:0] out_data,
    output logic                 ram_wen,
    output logic [ADDR_SIZE-1:0] ram_waddr,
    output logic [ADDR_SIZE-1:0] ram_raddr,
    output logic [data_size-1:0] ram_d,
    input  logic [data_size-1:0] ram_q,
`ifdef K_FIFO2_CTRL_STATS_EN
    output logic [7:0]           conflict_cnt,
`endif
    output logic [COUNT_W-1:0]   count
);

    logic [ADDR_SIZE-1:0] wptr;
    logic [ADDR_SIZE-1:0] rptr;
    logic [ADDR_SIZE-1:0] waddr_q;
    logic [ADDR_SIZE-1:0] raddr_q;
    logic [data_size-1:0] d_q;
    logic [1:0]           grant;
    logic                 wr_req;
    logic                 rd_req;
    logic                 wr_grant;
    logic                 rd_grant;

    // Writes are masked while rst_n is low so nothing reaches the RAM during reset
    assign wr_req = rst_n && in_valid && (count < COUNT_W'(DEPTH));
    assign rd_req = (count != '0) && (!out_valid || out_ready);

    k_fifo2_rr_arb u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_req (wr_req),
        .rd_req (rd_req),
        .grant  (grant)
    );

    assign wr_grant = grant[GNT_WR_BIT];
    assign rd_grant = grant[GNT_RD_BIT];

    assign in_ready  = wr_req && wr_grant;
    assign ram_wen   = wr_grant;
    assign ram_waddr = wr_grant ? wptr : waddr_q;
    assign ram_d     = wr_grant ? in_data : d_q;
    assign ram_raddr = rd_grant ? rptr : raddr_q;
    assign out_data  = ram_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (wr_grant) begin
                wptr  <= wptr + ADDR_SIZE'(1);
                count <= count + COUNT_W'(1);
            end else if (rd_grant) begin
                rptr  <= rptr + ADDR_SIZE'(1);
                count <= count - COUNT_W'(1);
            end
            if (rd_grant) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // RAM address/data lines keep their last driven value on idle cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_q <= '0;
            raddr_q <= '0;
            d_q     <= '0;
        end else begin
            if (wr_grant) begin
                waddr_q <= wptr;
                d_q     <= in_data;
            end
            if (rd_grant) begin
                raddr_q <= rptr;
            end
        end
    end

`ifdef K_FIFO2_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (wr_req && rd_req && (conflict_cnt != 8'hFF)) begin
            conflict_cnt <= conflict_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_k_fifo2_ctrl.sv
// Self-checking bench for k_fifo2_ctrl with a behavioural RAM and a queue-based reference model.
// Conflict counter checks are active when K_FIFO2_CTRL_STATS_EN is defined.
module tb_k_fifo2_ctrl;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       in_valid  = 1'b0;
    logic [7:0] in_data   = 8'h00;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       ram_wen;
    logic [0:0] ram_waddr;
    logic [0:0] ram_raddr;
    logic [7:0] ram_d;
    logic [7:0] ram_q;
    logic [1:0] count;
`ifdef K_FIFO2_CTRL_STATS_EN
    logic [7:0] conflict_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: RAM contents as a queue plus the entry presented on out_data
    bit [7:0] mq[$];
    bit       m_ov;
    bit [7:0] m_od;
    bit       m_last_wr;
    int       m_conf;
    int       m_wcnt;
    int       m_rcnt;
    bit [7:0] last_wd;
    bit       e_wr;
    bit       e_rd;
    bit       e_conf;

    logic [7:0] mem [2];

    always #5 clk = ~clk;

    k_fifo2_ctrl #(.data_size(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .ram_wen      (ram_wen),
        .ram_waddr    (ram_waddr),
        .ram_raddr    (ram_raddr),
        .ram_d        (ram_d),
        .ram_q        (ram_q),
`ifdef K_FIFO2_CTRL_STATS_EN
        .conflict_cnt (conflict_cnt),
`endif
        .count        (count)
    );

    // External RAM: a read is issued exactly when the controller has a read request and is not writing
    always @(posedge clk) begin
        if (ram_wen) begin
            mem[ram_waddr] <= ram_d;
        end else if ((count != 2'd0) && (!out_valid || out_ready)) begin
            ram_q <= mem[ram_raddr];
        end
    end

    function automatic void model_reset();
        mq.delete();
        m_ov      = 1'b0;
        m_od      = 8'h00;
        m_last_wr = 1'b1;
        m_conf    = 0;
        m_wcnt    = 0;
        m_rcnt    = 0;
        last_wd   = 8'h00;
    endfunction

    function automatic void model_eval();
        bit wq;
        bit rq;
        wq = in_valid && (mq.size() < 2);
        rq = (mq.size() > 0) && (!m_ov || out_ready);
        e_conf = wq && rq;
        if (wq && rq) begin
            e_wr = !m_last_wr;
            e_rd = m_last_wr;
        end else begin
            e_wr = wq;
            e_rd = rq;
        end
    endfunction

    function automatic void model_commit();
        if (e_conf && m_conf < 255) m_conf++;
        if (e_wr) begin
            mq.push_back(in_data);
            last_wd   = in_data;
            m_wcnt++;
            m_last_wr = 1'b1;
        end
        if (e_rd) begin
            m_od      = mq.pop_front();
            m_ov      = 1'b1;
            m_last_wr = 1'b0;
            m_rcnt++;
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
    endfunction

    task automatic applyStimulus(input logic iv, input logic [7:0] d, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        model_eval();
    endtask

    task automatic commitCycle();
        @(posedge clk);
        model_commit();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h33;
        @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (ram_wen !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_wen: got %b expected 0", ram_wen); end
        checks++; if (count !== 2'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
`ifdef K_FIFO2_CTRL_STATS_EN
        checks++; if (conflict_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_conflict_cnt: got %0d expected 0", conflict_cnt); end
`endif
        @(posedge clk);
        #1;
        checks++; if (count !== 2'd0) begin errors++; $display("[TB] FAIL reset_no_write: count got %0d expected 0", count); end
        do_reset();
    endtask

    task automatic test_single_push();
        do_reset();
        applyStimulus(1'b1, 8'h11, 1'b0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_in_ready: got %b expected 1", in_ready); end
        checks++; if (ram_wen !== 1'b1) begin errors++; $display("[TB] FAIL single_wen_c1: got %b expected 1", ram_wen); end
        checks++; if (ram_d !== 8'h11) begin errors++; $display("[TB] FAIL single_ram_d: got %h expected 11", ram_d); end
        commitCycle();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checks++; if (ram_wen !== 1'b0) begin errors++; $display("[TB] FAIL single_wen_c2: got %b expected 0", ram_wen); end
        checks++; if (count !== 2'd1) begin errors++; $display("[TB] FAIL single_count_c2: got %0d expected 1", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_ov_c2: got %b expected 0", out_valid); end
        commitCycle();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_ov_c3: got %b expected 1", out_valid); end
        checks++; if (out_data !== 8'h11) begin errors++; $display("[TB] FAIL single_out_data: got %h expected 11", out_data); end
        checks++; if (count !== 2'd0) begin errors++; $display("[TB] FAIL single_count_c3: got %0d expected 0", count); end
        commitCycle();
    endtask

    task automatic test_fill_and_drain();
        bit [7:0] d;
        bit [7:0] got[$];
        int       acc;
        do_reset();
        d   = 8'h01;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, d, 1'b0);
            checks++; if (in_ready !== e_wr) begin errors++; $display("[TB] FAIL fill_in_ready cyc=%0d: got %b expected %b", i, in_ready, e_wr); end
            if (in_ready === 1'b1) acc++;
            if (e_wr && d < 8'h04) d++;
            commitCycle();
        end
        applyStimulus(1'b1, d, 1'b0);
        checks++; if (acc != 3) begin errors++; $display("[TB] FAIL fill_accepted: got %0d expected 3", acc); end
        checks++; if (count !== 2'd2) begin errors++; $display("[TB] FAIL fill_count: got %0d expected 2", count); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL fill_out_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 8'h01) begin errors++; $display("[TB] FAIL fill_out_data: got %h expected 01", out_data); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_held_off: got %b expected 0", in_ready); end
        commitCycle();
        for (int i = 0; i < 14; i++) begin
            applyStimulus(d <= 8'h04, d, 1'b1);
            checks++; if (in_ready !== e_wr) begin errors++; $display("[TB] FAIL drain_in_ready cyc=%0d: got %b expected %b", i, in_ready, e_wr); end
            checks++; if (out_valid !== m_ov) begin errors++; $display("[TB] FAIL drain_out_valid cyc=%0d: got %b expected %b", i, out_valid, m_ov); end
            if (out_valid === 1'b1) got.push_back(out_data);
            if (e_wr) d++;
            commitCycle();
        end
        checks++; if (got.size() != 4) begin errors++; $display("[TB] FAIL drain_len: got %0d expected 4", got.size()); end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            checks++; if (got[i] !== 8'(i + 1)) begin errors++; $display("[TB] FAIL drain_order idx=%0d: got %h expected %h", i, got[i], 8'(i + 1)); end
        end
    endtask

    task automatic test_alternate();
        do_reset();
        for (int i = 0; i < 21; i++) begin
            applyStimulus(1'b1, 8'($urandom), 1'b1);
            checks++; if (ram_wen !== (i % 2 == 0)) begin errors++; $display("[TB] FAIL alt_wen cyc=%0d: got %b expected %b", i, ram_wen, (i % 2 == 0)); end
            checks++; if (count !== 2'(i % 2)) begin errors++; $display("[TB] FAIL alt_count cyc=%0d: got %0d expected %0d", i, count, i % 2); end
            if (m_ov) begin
                checks++; if (out_data !== m_od) begin errors++; $display("[TB] FAIL alt_out_data cyc=%0d: got %h expected %h", i, out_data, m_od); end
            end
`ifdef K_FIFO2_CTRL_STATS_EN
            if (i == 20) begin
                checks++; if (conflict_cnt !== 8'd10) begin errors++; $display("[TB] FAIL alt_conflict_cnt: got %0d expected 10", conflict_cnt); end
            end
`endif
            commitCycle();
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'b1, 8'($urandom), 1'b1);
            checks++; if (ram_wen !== e_wr) begin errors++; $display("[TB] FAIL sat_wen cyc=%0d: got %b expected %b", i, ram_wen, e_wr); end
`ifdef K_FIFO2_CTRL_STATS_EN
            checks++; if (conflict_cnt !== 8'(m_conf)) begin errors++; $display("[TB] FAIL sat_cnt_track cyc=%0d: got %0d expected %0d", i, conflict_cnt, m_conf); end
`endif
            commitCycle();
        end
        applyStimulus(1'b0, 8'h00, 1'b1);
`ifdef K_FIFO2_CTRL_STATS_EN
        checks++; if (conflict_cnt !== 8'd255) begin errors++; $display("[TB] FAIL sat_conflict_cnt: got %0d expected 255", conflict_cnt); end
`endif
        checks++; if (out_data !== m_od) begin errors++; $display("[TB] FAIL sat_out_data: got %h expected %h", out_data, m_od); end
        commitCycle();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 1) == 1);
            checks++; if (in_ready !== e_wr) begin errors++; $display("[TB] FAIL rand_in_ready cyc=%0d: got %b expected %b", i, in_ready, e_wr); end
            checks++; if (ram_wen !== e_wr) begin errors++; $display("[TB] FAIL rand_wen cyc=%0d: got %b expected %b", i, ram_wen, e_wr); end
            checks++; if (count !== 2'(mq.size())) begin errors++; $display("[TB] FAIL rand_count cyc=%0d: got %0d expected %0d", i, count, mq.size()); end
            checks++; if (out_valid !== m_ov) begin errors++; $display("[TB] FAIL rand_out_valid cyc=%0d: got %b expected %b", i, out_valid, m_ov); end
            if (m_ov) begin
                checks++; if (out_data !== m_od) begin errors++; $display("[TB] FAIL rand_out_data cyc=%0d: got %h expected %h", i, out_data, m_od); end
            end
            if (e_wr) begin
                checks++; if (ram_waddr !== 1'(m_wcnt)) begin errors++; $display("[TB] FAIL rand_waddr cyc=%0d: got %0d expected %0d", i, ram_waddr, 1'(m_wcnt)); end
                checks++; if (ram_d !== in_data) begin errors++; $display("[TB] FAIL rand_ram_d cyc=%0d: got %h expected %h", i, ram_d, in_data); end
            end else if (m_wcnt > 0) begin
                checks++; if (ram_d !== last_wd) begin errors++; $display("[TB] FAIL rand_ram_d_hold cyc=%0d: got %h expected %h", i, ram_d, last_wd); end
            end
            if (e_rd) begin
                checks++; if (ram_raddr !== 1'(m_rcnt)) begin errors++; $display("[TB] FAIL rand_raddr cyc=%0d: got %0d expected %0d", i, ram_raddr, 1'(m_rcnt)); end
            end
`ifdef K_FIFO2_CTRL_STATS_EN
            checks++; if (conflict_cnt !== 8'(m_conf)) begin errors++; $display("[TB] FAIL rand_conflict cyc=%0d: got %0d expected %0d", i, conflict_cnt, m_conf); end
`endif
            commitCycle();
        end
    endtask

    task automatic test_midreset();
        bit found;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'(8'h50 + i), 1'b0);
            commitCycle();
            if (mq.size() == 2 && m_ov) break;
        end
        @(negedge clk);
        #1;
        checks++; if (count !== 2'd2 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre: got count=%0d ov=%b expected count=2 ov=1", count, out_valid); end
        in_valid = 1'b1;
        in_data  = 8'hEE;
        rst_n    = 1'b0;
        #1;
        checks++; if (count !== 2'd0) begin errors++; $display("[TB] FAIL midrst_count: got %0d expected 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_in_ready: got %b expected 0", in_ready); end
        checks++; if (ram_wen !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ram_wen: got %b expected 0", ram_wen); end
        @(posedge clk);
        #1;
        checks++; if (count !== 2'd0) begin errors++; $display("[TB] FAIL midrst_no_write: count got %0d expected 0", count); end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        model_reset();
        applyStimulus(1'b1, 8'hAA, 1'b0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_push: got %b expected 1", in_ready); end
        commitCycle();
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            if (out_valid === 1'b1) begin
                found = 1'b1;
                checks++; if (out_data !== 8'hAA) begin errors++; $display("[TB] FAIL midrst_first_out: got %h expected aa", out_data); end
            end
            commitCycle();
        end
        if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL midrst_timeout: got no out_valid expected out_valid within 6 cycles");
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_push();
        test_fill_and_drain();
        test_alternate();
        test_saturate();
        test_random();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
